// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration-chain loader: FSM states and default widths.
package fpga_cfg_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int LEN_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } cfg_state_t;

   function automatic logic is_busy(input cfg_state_t s);
      return (s == LOAD) || (s == SHIFT) || (s == LATCH);
   endfunction

endpackage

// File: rtl/fpga_cfg_readback.sv
// Collects the chain tail bit on every shift cycle into LSB-first words (used when FPGA_CFG_READBACK_EN is defined).
module fpga_cfg_readback
   import fpga_cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic              clr,
   input  logic              sample,
   input  logic              last,
   input  logic              ret,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] acc_nxt;
   logic [IDX_W-1:0]  idx;

   // Writing by index leaves the unfilled upper bits of a short final word at zero.
   assign acc_nxt = acc | (WORD_W'(ret) << idx);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         acc      <= '0;
         idx      <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (clr) begin
            acc <= '0;
            idx <= '0;
         end else if (sample) begin
            if ((idx == IDX_W'(WORD_W - 1)) || last) begin
               rb_data  <= acc_nxt;
               rb_valid <= 1'b1;
               acc      <= '0;
               idx      <= '0;
            end else begin
               acc <= acc_nxt;
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/fpga_cfg_ctrl.sv
// Serial configuration-chain loader: accepts words, shifts chain_len bits LSB-first, then pulses cfg_set.
// Optional readback of the chain tail is enabled with `define FPGA_CFG_READBACK_EN.
module fpga_cfg_ctrl
   import fpga_cfg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clock,
   input  logic              resetb,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  chain_len,
   input  logic              wr_valid,
   input  logic [WORD_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              cfg_en,
   output logic              cfg_data,
   input  logic              cfg_ret,
   output logic              cfg_set,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef FPGA_CFG_READBACK_EN
   ,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid
`endif
);

   localparam int CNT_W = $clog2(WORD_W + 1);

   cfg_state_t        state, state_nxt;
   logic [LEN_W-1:0]  remaining;
   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  word_bits;
   logic              err_q;

   logic idle_like, accept_start, reject_start, abort_hit, word_acc, shifting;

   assign idle_like    = (state == IDLE) || (state == DONE);
   assign accept_start = idle_like && start && (chain_len != '0);
   assign reject_start = idle_like && start && (chain_len == '0);
   assign abort_hit    = abort && is_busy(state);
   assign word_acc     = (state == LOAD) && wr_valid && !abort;
   assign shifting     = (state == SHIFT) && !abort;

   // A word carries at most WORD_W bits; the last one may be shorter and its upper bits are dropped.
   assign word_bits = (remaining >= LEN_W'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(remaining);

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (accept_start) state_nxt = LOAD;
         LOAD:       if (wr_valid) state_nxt = SHIFT;
         SHIFT:      if (bit_cnt == CNT_W'(1))
                        state_nxt = (remaining == LEN_W'(1)) ? LATCH : LOAD;
         LATCH:      state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (abort_hit) state_nxt = IDLE;
   end

   always_comb begin
      wr_ready = (state == LOAD);
      cfg_en   = (state == SHIFT);
      cfg_data = (state == SHIFT) && shreg[0];
      cfg_set  = (state == LATCH);
      busy     = is_busy(state);
      done     = (state == DONE);
      err      = err_q;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         remaining <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= reject_start;
         if (accept_start)  remaining <= chain_len;
         else if (shifting) remaining <= remaining - LEN_W'(1);
         if (word_acc) begin
            shreg   <= wr_data;
            bit_cnt <= word_bits;
         end else if (shifting) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
         end
      end
   end

`ifdef FPGA_CFG_READBACK_EN
   fpga_cfg_readback #(.WORD_W(WORD_W)) u_readback (
      .clock    (clock),
      .resetb   (resetb),
      .clr      (state == IDLE),
      .sample   (cfg_en),
      .last     (cfg_en && (remaining == LEN_W'(1))),
      .ret      (cfg_ret),
      .rb_data  (rb_data),
      .rb_valid (rb_valid)
   );
`else
   logic unused_cfg_ret;
   assign unused_cfg_ret = cfg_ret;
`endif

endmodule

// File: tb/tb_fpga_cfg_ctrl.sv
// Scoreboard bench for fpga_cfg_ctrl: expected chain bits are queued at stimulus time and popped on each cfg_en cycle.
`timescale 1ns/1ps
module tb_fpga_cfg_ctrl;

   logic        clock = 1'b0;
   logic        resetb = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] chain_len = '0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;
   logic        wr_ready, cfg_en, cfg_data, cfg_ret, cfg_set, busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;
   int en_total = 0, set_total = 0, rb_total = 0;
   bit exp_q[$];
   logic [31:0] rb_q[$];
   logic [31:0] words[3];

   always #5 clock = ~clock;

`ifdef FPGA_CFG_READBACK_EN
   logic [31:0] rb_data;
   logic        rb_valid;
   logic [63:0] chain = 64'h1234_5678_9ABC_DEF0;
   always @(posedge clock) if (cfg_en) chain <= {cfg_data, chain[63:1]};
   assign cfg_ret = chain[0];
`else
   assign cfg_ret = 1'b0;
`endif

   fpga_cfg_ctrl #(.WORD_W(32), .LEN_W(16)) dut (
      .clock     (clock),
      .resetb    (resetb),
      .start     (start),
      .abort     (abort),
      .chain_len (chain_len),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .cfg_en    (cfg_en),
      .cfg_data  (cfg_data),
      .cfg_ret   (cfg_ret),
      .cfg_set   (cfg_set),
      .busy      (busy),
      .done      (done),
      .err       (err)
`ifdef FPGA_CFG_READBACK_EN
      ,
      .rb_data   (rb_data),
      .rb_valid  (rb_valid)
`endif
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: one pop per shift cycle, pulse counters for cfg_set and readback.
   initial forever begin
      @(negedge clock);
      if (resetb) begin
         if (cfg_en) begin
            en_total++;
            if (exp_q.size() == 0) check_val("q_underflow", 64'(exp_q.size()), 64'd1);
            else                   check_val("cfg_data", 64'(cfg_data), 64'(exp_q.pop_front()));
         end
         if (cfg_set) set_total++;
`ifdef FPGA_CFG_READBACK_EN
         if (rb_valid) begin
            rb_total++;
            if (rb_q.size() != 0) check_val("rb_data", 64'(rb_data), 64'(rb_q.pop_front()));
         end
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_bits(input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(words[i / 32][i % 32]);
   endtask

   task automatic do_start(input int len);
      chain_len = 16'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_ready();
      int c = 0;
      while (!wr_ready && c < 200) begin
         tick();
         c++;
      end
      if (!wr_ready) check_val("ready_timeout", 64'(wr_ready), 64'd1);
   endtask

   task automatic feed(input int nwords, input int stall);
      for (int w = 0; w < nwords; w++) begin
         wr_valid = 1'b1;
         wr_data  = words[w];
         wait_ready();
         tick();
         if (stall > 0 && w < nwords - 1) begin
            wr_valid = 1'b0;
            wait_ready();
            start = 1'b1;
            chain_len = '0;
            tick();
            start = 1'b0;
            check_val("busy_start_err", 64'(err), 64'd0);
            for (int s = 1; s < stall; s++) begin
               check_val("stall_en", 64'(cfg_en), 64'd0);
               tick();
            end
         end
      end
      wr_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input int len, input int nwords, input int stall);
      int base_en, base_set, c;
      base_en  = en_total;
      base_set = set_total;
      push_bits(len);
      do_start(len);
      check_val({tag, "_busy"}, 64'(busy), 64'd1);
      feed(nwords, stall);
      c = 0;
      while (!done && c < 300) begin
         tick();
         c++;
      end
      check_val({tag, "_done"}, 64'(done), 64'd1);
      tick();
      check_val({tag, "_en_cnt"}, 64'(en_total - base_en), 64'(len));
      check_val({tag, "_set_cnt"}, 64'(set_total - base_set), 64'd1);
      check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
      check_val({tag, "_q_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int base_en, base_set;
      repeat (3) tick();
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_err", 64'(err), 64'd0);
      check_val("rst_ready", 64'(wr_ready), 64'd0);
      check_val("rst_en", 64'(cfg_en), 64'd0);
      check_val("rst_set", 64'(cfg_set), 64'd0);
      check_val("rst_data", 64'(cfg_data), 64'd0);
      resetb = 1'b1;
      tick();

`ifdef FPGA_CFG_READBACK_EN
      begin
         int base_rb;
         base_rb = rb_total;
         words[0] = 32'hCAFE_F00D;
         words[1] = 32'h0BAD_BEEF;
         rb_q.push_back(32'h9ABC_DEF0);
         rb_q.push_back(32'h1234_5678);
         run_load("rb", 64, 2, 0);
         tick();
         check_val("rb_count", 64'(rb_total - base_rb), 64'd2);
         check_val("rb_q_left", 64'(rb_q.size()), 64'd0);
      end
`endif

      words[0] = 32'hA5A5_0001;
      words[1] = 32'h8000_FFFF;
      run_load("basic64", 64, 2, 0);

      // Zero-length start from DONE: err pulse, state and done untouched.
      do_start(0);
      check_val("zero_err", 64'(err), 64'd1);
      check_val("zero_busy", 64'(busy), 64'd0);
      check_val("zero_ready", 64'(wr_ready), 64'd0);
      check_val("zero_done", 64'(done), 64'd1);
      tick();
      check_val("zero_err_clr", 64'(err), 64'd0);

      words[0] = 32'hFFFF_FFFF;
      words[1] = 32'hFFFF_FF0F;
      run_load("partial40", 40, 2, 0);

      words[0] = 32'h1357_9BDF;
      words[1] = 32'h2468_ACE0;
      run_load("stall64", 64, 2, 10);

      // Abort during the 20th shifted bit.
      base_en  = en_total;
      base_set = set_total;
      words[0] = 32'h5555_AAAA;
      words[1] = 32'h0F0F_F0F0;
      push_bits(64);
      do_start(64);
      wr_valid = 1'b1;
      wr_data  = words[0];
      wait_ready();
      tick();
      repeat (19) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wr_valid = 1'b0;
      check_val("abort_en", 64'(cfg_en), 64'd0);
      check_val("abort_busy", 64'(busy), 64'd0);
      check_val("abort_done", 64'(done), 64'd0);
      repeat (3) tick();
      check_val("abort_en_cnt", 64'(en_total - base_en), 64'd20);
      check_val("abort_no_set", 64'(set_total - base_set), 64'd0);
      exp_q.delete();

      words[0] = 32'h0F0F_1234;
      words[1] = 32'hDEAD_BEEF;
      run_load("after_abort", 64, 2, 0);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("idle_abort_done", 64'(done), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fpga_cfg_ctrl.md
FPGA_CFG_CTRL -- requirements
Module: fpga_cfg_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of a configuration word.
REQ-002 SHALL have parameter LEN_W, default 16, width of the chain-length field (bits).
REQ-003 SHALL have the following ports; one clock, reset asynchronous and active-low:
- clock  in  1  sole clock; all state updates on rising edge
- resetb  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load
- abort  in  1  one-cycle pulse; cancels a load
- chain_len  in  LEN_W  total chain bits; sampled on accepted start
- wr_valid  in  1  word available
- wr_data  in  WORD_W  configuration word, LSB shifted first
- wr_ready  out  1  controller accepts a word this cycle
- cfg_en  out  1  chain shift enable
- cfg_data  out  1  serial chain data, valid while cfg_en=1
- cfg_ret  in  1  chain tail return bit
- cfg_set  out  1  one-cycle latch pulse after the final bit
- busy  out  1  load in progress
- done  out  1  last load completed
- err  out  1  one-cycle pulse on a rejected start

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, SHIFT, LATCH, DONE.
REQ-005 IDLE/DONE + start with chain_len!=0 SHALL latch chain_len into remaining-bit counter, clear done, go to LOAD next cycle.
REQ-006 start with chain_len==0 SHALL pulse err for one cycle and leave state and done unchanged.
REQ-007 start while busy SHALL be ignored: no err, no state change.
REQ-008 wr_ready SHALL be 1 only in LOAD; a word is accepted when wr_valid&&wr_ready.
REQ-009 Accepted word SHALL be copied to a shift register; state moves to SHIFT next cycle.
REQ-010 In SHIFT, each cycle SHALL assert cfg_en, drive cfg_data = shift-register bit 0, shift right, decrement the remaining counter.
REQ-011 SHIFT SHALL last min(WORD_W, remaining) cycles; unused upper bits of a partial last word SHALL be discarded.
REQ-012 After a word: remaining>0 SHALL return to LOAD; remaining==0 SHALL go to LATCH.
REQ-013 LATCH SHALL last one cycle with cfg_set=1, cfg_en=0, then go to DONE.
REQ-014 DONE SHALL hold done=1 until the next accepted start or reset.
REQ-015 busy SHALL be 1 exactly in LOAD, SHIFT, LATCH.
REQ-016 wr_valid low in LOAD SHALL stall indefinitely with cfg_en=0; the chain is not shifted.
REQ-017 abort in any busy state SHALL go to IDLE next cycle: cfg_en=0, no cfg_set, done=0; abort takes priority over all other events that cycle.
REQ-018 abort in IDLE/DONE SHALL have no effect.
REQ-019 Total cfg_en-high cycles per completed load SHALL equal chain_len exactly.

Reset
REQ-020 resetb low SHALL asynchronously force IDLE, all outputs 0, counters and shift register 0.
REQ-021 Reset mid-load SHALL not produce cfg_set; the chain contents are undefined until the next complete load.

Configuration
REQ-022 With FPGA_CFG_READBACK_EN defined, SHALL add outputs rb_data (WORD_W) and rb_valid (1); cfg_ret sampled each cfg_en cycle into a WORD_W shift register (LSB-first); rb_valid pulses one cycle after every WORD_W samples and after the final sample of a load (partial word zero-padded high).
REQ-023 Without FPGA_CFG_READBACK_EN, SHALL have no rb_* ports and ignore cfg_ret.

Structure
REQ-024 FSM state enum and WORD_W/LEN_W defaults SHALL reside in shared package fpga_cfg_pkg.
REQ-025 Bit counter and shift register SHALL be inline; optional sub-module fpga_cfg_readback holds REQ-022 logic.

Verification
REQ-026 chain_len=64, words 0xA5A5_0001, 0x8000_FFFF, wr_valid always 1 -> 64 cfg_en cycles, cfg_data matches LSB-first stream, one cfg_set, done=1.
REQ-027 chain_len=40, words 0xFFFF_FFFF, 0xFFFF_FF0F -> 40 cfg_en cycles; last 8 bits 1111_0000 order 1,1,1,1,0,0,0,0; bits 8-31 of word 2 never shifted.
REQ-028 chain_len=0 start -> err pulse 1 cycle, busy=0, wr_ready=0.
REQ-029 chain_len=64, abort after 20 shifted bits -> IDLE next cycle, no cfg_set, done=0; new start then completes normally.
REQ-030 wr_valid deasserted 10 cycles between words -> cfg_en=0 for stall, total cfg_en count still 64.
REQ-031 FPGA_CFG_READBACK_EN, cfg_ret looped to a 64-bit chain preloaded 0x1234_5678_9ABC_DEF0 -> rb_data 0x9ABC_DEF0 then 0x1234_5678, two rb_valid pulses.
